// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared types and default widths for the arithmetic datapath
package arith_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    TRACK = 1'b1
  } state_e;

  localparam int ARITH_W   = 32;
  localparam int RUN_CNT_W = 6;

endpackage

// File: rtl/sign_zero_cmp.sv
// rtl/sign_zero_cmp.sv - combinational sign and zero detect for a two's-complement operand
module sign_zero_cmp #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             neg_o,
  output logic             zero_o
);

  assign neg_o  = data_i[WIDTH-1];
  assign zero_o = (data_i == '0);

endmodule

// File: rtl/sign_flag_tracker.sv
// rtl/sign_flag_tracker.sv - registered sign/zero flags, sticky negative and saturating non-negative run count
module sign_flag_tracker
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_W,
  parameter int CNT_W = RUN_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr,
  output logic             out_valid,
  output logic             neg,
  output logic             nonneg,
  output logic             zero,
  output logic             sticky_neg,
  output logic [CNT_W-1:0] run_cnt,
  output logic             run_sat,
  output logic             seen
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q;
  logic               out_valid_q;
  logic               neg_q;
  logic               nonneg_q;
  logic               zero_q;
  logic               sticky_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               s_neg;
  logic               s_zero;
  logic [CNT_W-1:0]   cnt_base;
  logic [CNT_W-1:0]   cnt_d;

  sign_zero_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .data_i (in_data),
    .neg_o  (s_neg),
    .zero_o (s_zero)
  );

  // A clear in the same cycle as a sample takes effect before the sample is counted.
  always_comb begin
    cnt_base = clr ? '0 : cnt_q;
    cnt_d    = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      neg_q       <= 1'b0;
      nonneg_q    <= 1'b0;
      zero_q      <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        state_q  <= TRACK;
        neg_q    <= s_neg;
        nonneg_q <= ~s_neg;
        zero_q   <= s_zero;
        sticky_q <= s_neg | (sticky_q & ~clr);
        cnt_q    <= s_neg ? '0 : cnt_d;
      end else if (clr) begin
        state_q  <= EMPTY;
        sticky_q <= 1'b0;
        cnt_q    <= '0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign neg        = neg_q;
  assign nonneg     = nonneg_q;
  assign zero       = zero_q;
  assign sticky_neg = sticky_q;
  assign run_cnt    = cnt_q;
  assign run_sat    = (cnt_q == CNT_MAX);
  assign seen       = (state_q == TRACK);

endmodule

// File: tb/tb_sign_flag_tracker.sv
// tb/tb_sign_flag_tracker.sv - table-driven scoreboard bench for sign_flag_tracker
module tb_sign_flag_tracker;

  typedef struct {
    logic        v;
    logic        c;
    logic [31:0] d;
    logic        ov;
    logic        ng;
    logic        nn;
    logic        z;
    logic        st;
    int          cnt;
    logic        sat;
    logic        sn;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        a_v, a_c, a_ov, a_ng, a_nn, a_z, a_st, a_sat, a_sn;
  logic [31:0] a_d;
  logic [5:0]  a_cnt;
  logic        b_v, b_c, b_ov, b_ng, b_nn, b_z, b_st, b_sat, b_sn;
  logic [31:0] b_d;
  logic [1:0]  b_cnt;

  int total = 0;
  int bad = 0;
  vec_t sb[$];
  vec_t tab_a[$];
  vec_t tab_b[$];

  always #5 clk = ~clk;

  sign_flag_tracker dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_v), .in_data(a_d), .clr(a_c),
    .out_valid(a_ov), .neg(a_ng), .nonneg(a_nn), .zero(a_z), .sticky_neg(a_st),
    .run_cnt(a_cnt), .run_sat(a_sat), .seen(a_sn)
  );

  sign_flag_tracker #(.WIDTH(32), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_v), .in_data(b_d), .clr(b_c),
    .out_valid(b_ov), .neg(b_ng), .nonneg(b_nn), .zero(b_z), .sticky_neg(b_st),
    .run_cnt(b_cnt), .run_sat(b_sat), .seen(b_sn)
  );

  function automatic vec_t mk(logic v, logic c, logic [31:0] d, logic ov, logic ng,
                              logic nn, logic z, logic st, int cnt, logic sat, logic sn);
    vec_t r;
    r.v = v; r.c = c; r.d = d; r.ov = ov; r.ng = ng; r.nn = nn; r.z = z;
    r.st = st; r.cnt = cnt; r.sat = sat; r.sn = sn;
    return r;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_outs(string tag, int which, vec_t e);
    if (which == 0) begin
      chk({tag, ".out_valid"}, a_ov, e.ov);  chk({tag, ".neg"}, a_ng, e.ng);
      chk({tag, ".nonneg"}, a_nn, e.nn);     chk({tag, ".zero"}, a_z, e.z);
      chk({tag, ".sticky"}, a_st, e.st);     chk({tag, ".run_cnt"}, int'(a_cnt), e.cnt);
      chk({tag, ".run_sat"}, a_sat, e.sat);  chk({tag, ".seen"}, a_sn, e.sn);
    end else begin
      chk({tag, ".out_valid"}, b_ov, e.ov);  chk({tag, ".neg"}, b_ng, e.ng);
      chk({tag, ".nonneg"}, b_nn, e.nn);     chk({tag, ".zero"}, b_z, e.z);
      chk({tag, ".sticky"}, b_st, e.st);     chk({tag, ".run_cnt"}, int'(b_cnt), e.cnt);
      chk({tag, ".run_sat"}, b_sat, e.sat);  chk({tag, ".seen"}, b_sn, e.sn);
    end
  endtask

  task automatic apply(string tag, int which, vec_t v);
    vec_t e;
    @(negedge clk);
    a_v = 1'b0; a_c = 1'b0; a_d = 'x;
    b_v = 1'b0; b_c = 1'b0; b_d = 'x;
    if (which == 0) begin
      a_v = v.v; a_c = v.c; a_d = v.v ? v.d : 32'hxxxx_xxxx;
    end else begin
      b_v = v.v; b_c = v.c; b_d = v.v ? v.d : 32'hxxxx_xxxx;
    end
    sb.push_back(v);
    @(posedge clk);
    #1;
    a_v = 1'b0; a_c = 1'b0;
    b_v = 1'b0; b_c = 1'b0;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s.scoreboard: got empty queue expected one entry", tag);
    end else begin
      e = sb.pop_front();
      total--;
      chk_outs(tag, which, e);
    end
  endtask

  initial begin
    vec_t zero_v;
    a_v = 1'b0; a_c = 1'b0; a_d = '0;
    b_v = 1'b0; b_c = 1'b0; b_d = '0;
    zero_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //            v  c  data          ov ng nn z  st cnt sat seen
    tab_a.push_back(mk(1, 0, 32'hFFFF_FFFF, 1, 1, 0, 0, 1, 0, 0, 1));
    tab_a.push_back(mk(0, 1, 32'h0,         0, 1, 0, 0, 0, 0, 0, 0));
    tab_a.push_back(mk(1, 0, 32'd0,         1, 0, 1, 1, 0, 1, 0, 1));
    tab_a.push_back(mk(1, 0, 32'd5,         1, 0, 1, 0, 0, 2, 0, 1));
    tab_a.push_back(mk(1, 0, 32'd7,         1, 0, 1, 0, 0, 3, 0, 1));
    tab_a.push_back(mk(0, 0, 32'h0,         0, 0, 1, 0, 0, 3, 0, 1));
    tab_a.push_back(mk(1, 0, 32'hFFFF_FFFC, 1, 1, 0, 0, 1, 0, 0, 1));
    tab_a.push_back(mk(1, 0, 32'd10,        1, 0, 1, 0, 1, 1, 0, 1));
    tab_a.push_back(mk(0, 1, 32'h0,         0, 0, 1, 0, 0, 0, 0, 0));
    tab_a.push_back(mk(1, 0, 32'hFFFF_FFFF, 1, 1, 0, 0, 1, 0, 0, 1));
    tab_a.push_back(mk(1, 0, 32'd1,         1, 0, 1, 0, 1, 1, 0, 1));
    tab_a.push_back(mk(1, 0, 32'd2,         1, 0, 1, 0, 1, 2, 0, 1));
    tab_a.push_back(mk(1, 0, 32'd3,         1, 0, 1, 0, 1, 3, 0, 1));
    tab_a.push_back(mk(1, 0, 32'h7FFF_FFFF, 1, 0, 1, 0, 1, 4, 0, 1));
    tab_a.push_back(mk(1, 1, 32'hFFFF_FFFE, 1, 1, 0, 0, 1, 0, 0, 1));
    tab_a.push_back(mk(1, 1, 32'd9,         1, 0, 1, 0, 0, 1, 0, 1));

    tab_b.push_back(mk(1, 0, 32'd1,         1, 0, 1, 0, 0, 1, 0, 1));
    tab_b.push_back(mk(1, 0, 32'd1,         1, 0, 1, 0, 0, 2, 0, 1));
    tab_b.push_back(mk(1, 0, 32'd1,         1, 0, 1, 0, 0, 3, 1, 1));
    tab_b.push_back(mk(1, 0, 32'd1,         1, 0, 1, 0, 0, 3, 1, 1));
    tab_b.push_back(mk(1, 0, 32'd1,         1, 0, 1, 0, 0, 3, 1, 1));
    tab_b.push_back(mk(1, 0, 32'd1,         1, 0, 1, 0, 0, 3, 1, 1));
    tab_b.push_back(mk(1, 0, 32'h8000_0000, 1, 1, 0, 0, 1, 0, 0, 1));

    #3;
    chk_outs("reset_a", 0, zero_v);
    chk_outs("reset_b", 1, zero_v);
    #9 rst_n = 1'b1;

    foreach (tab_a[i]) apply($sformatf("a%0d", i), 0, tab_a[i]);
    foreach (tab_b[i]) apply($sformatf("b%0d", i), 1, tab_b[i]);

    // Asynchronous reset in the middle of a valid stream.
    @(negedge clk);
    a_v = 1'b1; a_d = 32'd6;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_outs("async_a", 0, zero_v);
    chk_outs("async_b", 1, zero_v);
    a_v = 1'b0;
    #1 rst_n = 1'b1;
    apply("post_reset", 0, mk(1, 0, 32'd3, 1, 0, 1, 0, 0, 1, 0, 1));
    apply("post_idle",  0, mk(0, 0, 32'd0, 0, 0, 1, 0, 0, 1, 0, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
